// File: rtl/im_arbiter.sv
// Two-port arbiter for the single-port instruction memory: fetch (read-only) and loader (read/write).
// Every access runs IDLE -> ACCESS -> PARK so the IM always sees an address change between accesses.
module im_arbiter #(
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [31:0] addr0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [31:0] rdata1,
  output logic        err1,
  input  logic        load_lock,
  output logic        im_wena,
  output logic        im_rena,
  output logic [31:0] im_addr,
  output logic [31:0] im_data_in,
  input  logic [31:0] im_data_out
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_PARK   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          rr_q, rr_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          err1_q, err1_d;
  logic          wena_q, wena_d, rena_q, rena_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_in_q, data_in_d;
  logic          elig0, elig1, win1;

  // State and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rr_q      <= 1'b0;
      wait_q    <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      err1_q    <= 1'b0;
      wena_q    <= 1'b0;
      rena_q    <= 1'b0;
      addr_q    <= '0;
      data_in_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      wait_q    <= wait_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      err1_q    <= err1_d;
      wena_q    <= wena_d;
      rena_q    <= rena_d;
      addr_q    <= addr_d;
      data_in_q <= data_in_d;
    end
  end

  // Next-state and next-output logic; memory-side outputs default to the parked (all-zero) value
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    wait_d    = wait_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    err1_d    = 1'b0;
    wena_d    = 1'b0;
    rena_d    = 1'b0;
    addr_d    = '0;
    data_in_d = '0;
    elig0     = req0 && !load_lock;
    elig1     = req1;
    if (ARB_MODE == 1) begin
      win1 = elig1 && (!elig0 || (wait_q >= CW'(MAX_WAIT)));
    end else begin
      win1 = elig1 && (!elig0 || rr_q);
    end

    case (state_q)
      S_IDLE: begin
        if (elig0 || elig1) begin
          state_d = S_ACCESS;
          rr_d    = !win1;
          if (win1) begin
            gnt1_d    = 1'b1;
            addr_d    = addr1;
            rena_d    = !we1;
            wena_d    = we1 && (addr1 != '0);
            err1_d    = we1 && (addr1 == '0);
            data_in_d = we1 ? wdata1 : '0;
            wait_d    = '0;
          end else begin
            gnt0_d = 1'b1;
            addr_d = addr0;
            rena_d = 1'b1;
            // Port 1 lost this round: age it toward the forced grant, saturating
            if (req1 && (wait_q != '1)) wait_d = wait_q + CW'(1);
          end
        end
      end
      S_ACCESS: begin
        state_d = S_PARK;
        if (rena_q) begin
          if (gnt0_q) begin
            rvalid0_d = 1'b1;
            rdata0_d  = im_data_out;
          end else begin
            rvalid1_d = 1'b1;
            rdata1_d  = im_data_out;
          end
        end
      end
      S_PARK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign rvalid0    = rvalid0_q;
  assign rvalid1    = rvalid1_q;
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;
  assign err1       = err1_q;
  assign im_wena    = wena_q;
  assign im_rena    = rena_q;
  assign im_addr    = addr_q;
  assign im_data_in = data_in_q;

endmodule

// File: tb/tb_im_arbiter.sv
// Scoreboard bench for im_arbiter: round-robin instance (a) and fixed-priority MAX_WAIT=2 instance (b).
module tb_im_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we1 = 1'b0, load_lock = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata1 = '0;

  logic        gnt0_a, rvalid0_a, gnt1_a, rvalid1_a, err1_a, wena_a, rena_a;
  logic [31:0] rdata0_a, rdata1_a, iaddr_a, idin_a, idout_a;
  logic        gnt0_b, rvalid0_b, gnt1_b, rvalid1_b, err1_b, wena_b, rena_b;
  logic [31:0] rdata0_b, rdata1_b, iaddr_b, idin_b, idout_b;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] model_mem [int];
  logic [31:0] q_rd0 [$];
  logic [31:0] q_rd1 [$];
  int          q_gnt [$];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  im_arbiter #(.ARB_MODE(0), .MAX_WAIT(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .req0(req0), .addr0(addr0), .gnt0(gnt0_a), .rvalid0(rvalid0_a),
    .rdata0(rdata0_a), .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1_a),
    .rvalid1(rvalid1_a), .rdata1(rdata1_a), .err1(err1_a), .load_lock(load_lock),
    .im_wena(wena_a), .im_rena(rena_a), .im_addr(iaddr_a), .im_data_in(idin_a), .im_data_out(idout_a));

  im_arbiter #(.ARB_MODE(1), .MAX_WAIT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req0(req0), .addr0(addr0), .gnt0(gnt0_b), .rvalid0(rvalid0_b),
    .rdata0(rdata0_b), .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1_b),
    .rvalid1(rvalid1_b), .rdata1(rdata1_b), .err1(err1_b), .load_lock(load_lock),
    .im_wena(wena_b), .im_rena(rena_b), .im_addr(iaddr_b), .im_data_in(idin_b), .im_data_out(idout_b));

  // Simple IM models: write on the edge, combinational read
  always @(posedge clk) if (wena_a) mem_a[iaddr_a[7:0]] <= idin_a;
  always @(posedge clk) if (wena_b) mem_b[iaddr_b[7:0]] <= idin_b;
  assign idout_a = mem_a[iaddr_a[7:0]];
  assign idout_b = mem_b[iaddr_b[7:0]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access on instance a: wait for gnt, check ACCESS and PARK cycles, score read data
  task automatic access(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    bit got;
    bit exp_err;
    logic [31:0] exp;
    got = 1'b0;
    exp_err = port && we && (addr == 32'h0);
    if (!we) begin
      exp = model_mem.exists(int'(addr)) ? model_mem[int'(addr)] : 32'h0;
      if (port) q_rd1.push_back(exp); else q_rd0.push_back(exp);
    end
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
    else begin req0 = 1'b1; addr0 = addr; end
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (port ? gnt1_a : gnt0_a) got = 1'b1;
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL gnt_timeout port=%0d addr=%h: no grant within 20 cycles", port, addr);
      req0 = 1'b0; req1 = 1'b0;
      return;
    end
    req0 = 1'b0; req1 = 1'b0;
    vectors++;
    if (iaddr_a !== addr || wena_a !== (we && addr != 0) || rena_a !== !we || err1_a !== exp_err) begin
      miscompares++;
      $display("FAIL access_cycle port=%0d: addr=%h wena=%b rena=%b err1=%b, required addr=%h wena=%b rena=%b err1=%b",
               port, iaddr_a, wena_a, rena_a, err1_a, addr, (we && addr != 0), !we, exp_err);
    end
    if (we && addr != 0) begin
      vectors++;
      if (idin_a !== wdata) begin
        miscompares++;
        $display("FAIL write_data: im_data_in=%h required %h", idin_a, wdata);
      end
      model_mem[int'(addr)] = wdata;
    end
    tick();
    vectors++;
    if (iaddr_a !== 0 || wena_a !== 0 || rena_a !== 0 || (port ? rvalid1_a : rvalid0_a) !== !we) begin
      miscompares++;
      $display("FAIL park_cycle port=%0d: addr=%h wena=%b rena=%b rvalid=%b, required 0 0 0 %b",
               port, iaddr_a, wena_a, rena_a, (port ? rvalid1_a : rvalid0_a), !we);
    end
    if ((port ? rvalid1_a : rvalid0_a) && !we) begin
      exp = port ? q_rd1.pop_front() : q_rd0.pop_front();
      vectors++;
      if ((port ? rdata1_a : rdata0_a) !== exp) begin
        miscompares++;
        $display("FAIL rdata port=%0d: got %h required %h", port, (port ? rdata1_a : rdata0_a), exp);
      end
    end
    tick();
  endtask

  // Both ports held reading; grant order checked against q_gnt on the selected instance
  task automatic run_contention(input bit sel);
    int last;
    bit g0, g1;
    int exp, port;
    logic [31:0] a;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    load_lock = 1'b0; req0 = 1'b1; req1 = 1'b1; we1 = 1'b0; addr0 = 32'h10; addr1 = 32'h20;
    last = -2;
    for (int c = 1; c <= 18; c++) begin
      tick();
      g0 = sel ? gnt0_b : gnt0_a;
      g1 = sel ? gnt1_b : gnt1_a;
      a  = sel ? iaddr_b : iaddr_a;
      if (g0 || g1) begin
        exp  = (q_gnt.size() != 0) ? q_gnt.pop_front() : -1;
        port = g1 ? 1 : 0;
        vectors++;
        if ((g0 && g1) || port != exp || (c - last) != 3) begin
          miscompares++;
          $display("FAIL grant_order inst=%0d cycle=%0d: gnt0=%b gnt1=%b gap=%0d, required port %0d gap 3",
                   sel, c, g0, g1, c - last, exp);
        end
        last = c;
      end else if (c - last == 1) begin
        vectors++;
        if (a !== 0) begin
          miscompares++;
          $display("FAIL park_addr inst=%0d cycle=%0d: im_addr=%h required 0", sel, c, a);
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    vectors++;
    if (q_gnt.size() != 0) begin
      miscompares++;
      $display("FAIL grant_count inst=%0d: %0d expected grants missing, required 0", sel, q_gnt.size());
      q_gnt.delete();
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    vectors++;
    if ({gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, err1_a, wena_a, rena_a} !== 7'b0 ||
        {iaddr_a, idin_a, rdata0_a, rdata1_a} !== 128'b0) begin
      miscompares++;
      $display("FAIL reset_a: control=%b addr=%h din=%h rd0=%h rd1=%h required all 0",
               {gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, err1_a, wena_a, rena_a}, iaddr_a, idin_a, rdata0_a, rdata1_a);
    end
    vectors++;
    if ({gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, err1_b, wena_b, rena_b} !== 7'b0 || iaddr_b !== 0) begin
      miscompares++;
      $display("FAIL reset_b: control=%b addr=%h required all 0",
               {gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, err1_b, wena_b, rena_b}, iaddr_b);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    access(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    access(1'b0, 1'b0, 32'h10, 32'h0);
  endtask

  task automatic test_back_to_back();
    access(1'b1, 1'b1, 32'h20, 32'h5);
    access(1'b1, 1'b1, 32'h20, 32'h6);
    access(1'b1, 1'b0, 32'h20, 32'h0);
    access(1'b1, 1'b1, 32'h0, 32'h77);
    access(1'b1, 1'b0, 32'h10, 32'h0);
  endtask

  task automatic test_load_lock();
    int n0, n1;
    n0 = 0; n1 = 0;
    load_lock = 1'b1; req0 = 1'b1; addr0 = 32'h10;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h30; wdata1 = 32'h1234;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (gnt0_a) n0++;
      if (gnt1_a) begin n1++; req1 = 1'b0; end
    end
    model_mem[32'h30] = 32'h1234;
    vectors++;
    if (n0 != 0 || n1 != 1) begin
      miscompares++;
      $display("FAIL lock_grants: gnt0 count=%0d gnt1 count=%0d, required 0 and 1", n0, n1);
    end
    q_rd0.push_back(model_mem[32'h10]);
    load_lock = 1'b0;
    tick();
    vectors++;
    if (gnt0_a !== 1'b1 || iaddr_a !== 32'h10 || rena_a !== 1'b1) begin
      miscompares++;
      $display("FAIL unlock_grant: gnt0=%b addr=%h rena=%b required 1 00000010 1", gnt0_a, iaddr_a, rena_a);
    end
    req0 = 1'b0;
    tick();
    vectors++;
    if (rvalid0_a !== 1'b1 || rdata0_a !== q_rd0.pop_front()) begin
      miscompares++;
      $display("FAIL unlock_read: rvalid0=%b rdata0=%h required 1 deadbeef", rvalid0_a, rdata0_a);
    end
    tick();
    access(1'b1, 1'b0, 32'h30, 32'h0);
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 6; i++) q_gnt.push_back(i % 2);
    run_contention(1'b0);
  endtask

  task automatic test_fixed_priority();
    for (int i = 0; i < 6; i++) q_gnt.push_back((i % 3 == 2) ? 1 : 0);
    run_contention(1'b1);
  endtask

  task automatic test_reset_abort();
    int nv;
    nv = 0;
    req0 = 1'b1; addr0 = 32'h10;
    tick();
    vectors++;
    if (gnt0_a !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_setup: gnt0=%b required 1", gnt0_a);
    end
    rst_n = 1'b0; req0 = 1'b0;
    tick();
    vectors++;
    if ({gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, err1_a, wena_a, rena_a} !== 7'b0 ||
        {iaddr_a, idin_a, rdata0_a, rdata1_a} !== 128'b0) begin
      miscompares++;
      $display("FAIL abort_outputs: control=%b addr=%h rd0=%h required all 0",
               {gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, err1_a, wena_a, rena_a}, iaddr_a, rdata0_a);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rvalid0_a || gnt0_a) nv++;
    end
    vectors++;
    if (nv != 0) begin
      miscompares++;
      $display("FAIL abort_rvalid: %0d cycles with rvalid0/gnt0 after reset, required 0", nv);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_load_lock();
    test_round_robin();
    test_fixed_priority();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
